sprite_blitter: RTL

- Consumer side of the object-descriptor table: takes a draw request (object id plus screen position), drives the id to the table, and latches the returned height, width and ROM base.
- Walks the sprite row-major, issuing sprite-ROM read addresses.
- Writes non-transparent pixels into the frame buffer, clipped to the screen.
- Sits between the game-logic draw scheduler and the frame-buffer write port.

---
 rtl/sprite_pkg.sv | 27 ++
 rtl/sprite_addr_gen.sv | 46 ++++
 rtl/sprite_blitter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared constants, FSM encoding and object ids for the sprite blitter.
package sprite_pkg;

  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam int PIX_W = 12;
  localparam logic [11:0] TRANS_KEY = 12'hF0F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // Object-descriptor ids; anything at or above OBJ_NUM maps to the 1x1 default.
  localparam logic [5:0] OBJ_BOX      = 6'd0;
  localparam logic [5:0] OBJ_TURTLER2 = 6'd35;
  localparam int         OBJ_NUM      = 36;

  // Linear frame-buffer address for an on-screen (sx, sy).
  function automatic logic [18:0] scr_lin(input logic [11:0] sx, input logic [11:0] sy);
    return 19'(sy) * 19'(SCR_W) + 19'(sx);
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Row-major sprite walker: col/row counters, running row_base (no multiplier)
// and sprite-ROM address generation. Freezes while stalled.
module sprite_addr_gen
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        stall,
  input  logic        flip,
  input  logic [10:0] h,
  input  logic [10:0] w,
  input  logic [18:0] base,
  output logic [10:0] col,
  output logic [10:0] row,
  output logic [18:0] addr,
  output logic        last
);

  logic [18:0] row_base;
  logic [10:0] col_eff;
  logic        step;

  assign step    = en && !stall;
  assign last    = (row == h - 11'd1) && (col == w - 11'd1);
  assign col_eff = flip ? (w - 11'd1 - col) : col;
  assign addr    = base + row_base + {8'd0, col_eff};

  // Advance one pixel per issued read; wrap col and bump row/row_base at row end.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (step) begin
      if (col == w - 11'd1) begin
        col      <= '0;
        row      <= row + 11'd1;
        row_base <= row_base + {8'd0, w};
      end else begin
        col <= col + 11'd1;
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter top: request/lookup FSM, two-stage ROM->FB pipeline with
// transparency and screen clipping, and frame-buffer back-pressure.
// Optional horizontal mirroring is enabled by defining SPRITE_MIRROR_EN.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int          SCR_W     = sprite_pkg::SCR_W,
  parameter int          SCR_H     = sprite_pkg::SCR_H,
  parameter int          PIX_W     = sprite_pkg::PIX_W,
  parameter logic [11:0] TRANS_KEY = sprite_pkg::TRANS_KEY
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_id,
  input  logic [9:0]       req_x,
  input  logic [8:0]       req_y,
`ifdef SPRITE_MIRROR_EN
  input  logic             req_flip,
`endif
  output logic [5:0]       obj_id,
  input  logic [10:0]      obj_h,
  input  logic [10:0]      obj_w,
  input  logic [18:0]      obj_addr,
  output logic             rom_en,
  output logic [18:0]      rom_addr,
  input  logic [PIX_W-1:0] rom_data,
  output logic             fb_we,
  output logic [18:0]      fb_addr,
  output logic [PIX_W-1:0] fb_data,
  input  logic             fb_ready,
  output logic             busy,
  output logic             done
);

  state_t      state, state_n;
  logic [5:0]  id_q;
  logic [9:0]  x_q;
  logic [8:0]  y_q;
  logic        flip_q;
  logic [10:0] h_q, w_q;
  logic [18:0] base_q;
  logic        run_en, issue, stall, last;
  logic [10:0] col, row;
  logic [18:0] gen_addr;
  logic        s1_valid;
  logic [10:0] s1_col, s1_row;
  logic [11:0] sx, sy;
  logic        on_screen;

  assign obj_id = id_q;

  // Whole pipeline freezes while a write is offered and refused.
  assign stall = fb_we && !fb_ready;
  assign issue = run_en && !stall;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic; zero-sized sprites bypass RUN/DRAIN.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (req_valid) state_n = S_LOOKUP;
      S_LOOKUP: state_n = (obj_h == 11'd0 || obj_w == 11'd0) ? S_DONE : S_RUN;
      S_RUN:    if (issue && last) state_n = S_DRAIN;
      S_DRAIN:  if (!stall) state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Control outputs decoded from state.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    run_en    = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_RUN:   run_en = 1'b1;
      S_DONE:  done   = 1'b1;
      default: ;
    endcase
  end

  // Request/descriptor latches and stage-1 registers (alongside the ROM read).
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      h_q      <= '0;
      w_q      <= '0;
      base_q   <= '0;
      s1_valid <= 1'b0;
      s1_col   <= '0;
      s1_row   <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        id_q <= req_id;
        x_q  <= req_x;
        y_q  <= req_y;
      end
      if (state == S_LOOKUP) begin
        h_q    <= obj_h;
        w_q    <= obj_w;
        base_q <= obj_addr;
      end
      if (!stall) begin
        s1_valid <= issue;
        s1_col   <= col;
        s1_row   <= row;
      end
    end
  end

`ifdef SPRITE_MIRROR_EN
  // Mirror flag travels with the request.
  always_ff @(posedge clk) begin
    if (rst)                             flip_q <= 1'b0;
    else if (state == S_IDLE && req_valid) flip_q <= req_flip;
  end
`else
  assign flip_q = 1'b0;
`endif

  sprite_addr_gen u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == S_LOOKUP),
    .en    (run_en),
    .stall (stall),
    .flip  (flip_q),
    .h     (h_q),
    .w     (w_q),
    .base  (base_q),
    .col   (col),
    .row   (row),
    .addr  (gen_addr),
    .last  (last)
  );

  assign rom_en   = issue;
  assign rom_addr = issue ? gen_addr : '0;

  // Stage 2: ROM word meets its screen position; 12-bit sums cannot wrap.
  assign sx        = {2'b00, x_q} + {1'b0, s1_col};
  assign sy        = {3'b000, y_q} + {1'b0, s1_row};
  assign on_screen = (sx < 12'(SCR_W)) && (sy < 12'(SCR_H));
  assign fb_we     = s1_valid && (rom_data != TRANS_KEY) && on_screen;
  assign fb_addr   = s1_valid ? scr_lin(sx, sy) : '0;
  assign fb_data   = s1_valid ? rom_data : '0;

endmodule
